// File: rtl/uart_tx.sv
// UART transmit stage: 16-entry byte FIFO feeding an 8N1 serializer, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       uout_valid,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_nx;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr, count;
  logic [7:0]       head;
  logic             push, pop, have_data;

  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bidx, bidx_nx;
  logic [7:0]    shift, shift_nx;
  logic          bit_end;
  logic          tx_nx;

  // FIFO: the full flag comes from the registered count, so a pop in the same
  // cycle never rescues a write that arrives while full.
  assign count     = wptr - rptr;
  assign fifo_full = (count == CNT_FULL);
  assign have_data = (count != '0);
  assign push      = uout_valid && !fifo_full;
  assign head      = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (uout_valid && fifo_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bidx  <= bidx_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at load time because the shift register is consumed.
  logic par;
  always_ff @(posedge clk) begin
    if (pop) par <= ^head;
  end
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    bidx_nx  = bidx;
    shift_nx = shift;
    pop      = 1'b0;
    bit_end  = (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (have_data) begin
          pop      = 1'b1;
          shift_nx = head;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nx   = '0;
          bidx_nx  = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[7:1]};
          if (bidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bidx_nx = bidx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (have_data) begin
            pop      = 1'b1;
            shift_nx = head;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_nx = 1'b1;
    case (state)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx = par;
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  // Line and busy flag are registered one cycle behind the state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx      <= tx_nx;
      tx_busy <= (state != IDLE) || have_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: queue-based line model checked every cycle, a line decoder,
// and directed scenarios with literal expectations (CLKS_PER_BIT=4, FIFO_AW=4).
module tb_uart_tx;
  localparam int C     = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB    = 11;
  localparam int FRAME = 44;
`else
  localparam int FB    = 10;
  localparam int FRAME = 40;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       uout_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, fifo_full, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(4)) dut (
    .clk(clk), .n_rst(n_rst), .uout_valid(uout_valid), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Model: byte queue plus the frame currently on the line.
  logic [7:0]  mq[$];
  int          rem = 0, pos = 0;
  logic [10:0] fr = '1;
  logic        lvl = 1'b1;
  logic        m_tx, m_busy, m_full, m_ovf;
  bit          m_ok = 0;

  always @(posedge clk) begin : model
    int   qs;
    logic busy_pre, lvl_pre;
    cyc++;
    if (!n_rst) begin
      mq.delete();
      rem = 0; pos = 0; lvl = 1'b1;
      m_tx = 1'b1; m_busy = 1'b0; m_full = 1'b0; m_ovf = 1'b0;
      m_ok = 1;
    end else begin
      qs = mq.size();
      busy_pre = (rem > 0) || (qs != 0);
      lvl_pre = lvl;
      if (uout_valid && qs == DEPTH) m_ovf = 1'b1;
      if (rem <= 1 && qs != 0) begin
        fr = frame_of(mq.pop_front());
        rem = FB * C;
        pos = 0;
      end else if (rem > 1) begin
        rem--;
        pos++;
      end else begin
        rem = 0;
      end
      lvl = (rem == 0) ? 1'b1 : fr[pos / C];
      if (uout_valid && qs != DEPTH) mq.push_back(tx_data);
      m_tx = lvl_pre;
      m_busy = busy_pre;
      m_full = (mq.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cyc_tx", tx, m_tx);
      chk("cyc_busy", tx_busy, m_busy);
      chk("cyc_full", fifo_full, m_full);
      chk("cyc_ovf", overflow, m_ovf);
    end
  end

  // Line decoder on the DUT output; frames cut by reset are discarded.
  logic [7:0] rx_q[$];
  int         st_q[$];
  bit         par_q[$];

  task automatic wait_n(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (!n_rst) ab = 1;
    end
  endtask

  initial begin : decoder
    forever begin
      @(negedge clk);
      if (n_rst && tx === 1'b0) begin : frame
        int s;
        logic [7:0] b;
        bit p, ab;
        s = cyc; ab = 0; p = 0; b = '0;
        wait_n(C + 1, ab);
        b[0] = tx;
        for (int k = 1; k < 8; k++) begin
          wait_n(C, ab);
          b[k] = tx;
        end
`ifdef UART_TX_PARITY_EN
        wait_n(C, ab);
        p = tx;
`endif
        wait_n(C, ab);
        if (!ab) begin
          rx_q.push_back(b);
          st_q.push_back(s);
          par_q.push_back(p);
        end
      end
    end
  end

  task automatic strobe(input logic [7:0] b, output int e);
    uout_valid = 1'b1;
    tx_data = b;
    @(posedge clk);
    #1 e = cyc;
  endtask

  task automatic wait_idle(input string name);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2000 && tx_busy !== 1'b0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk(name, tx_busy, 0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    st_q.delete();
    par_q.delete();
  endtask

  initial begin : main
    int e, fall, bfall;
    bit seen_low;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x31
    strobe(8'h31, e);
    uout_valid = 1'b0;
    fall = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin fall = cyc; break; end
    end
    chk("t1_latency", fall - e, 2);
    bfall = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) begin bfall = cyc; break; end
    end
    chk("t1_busy_fall", bfall - fall, FRAME);
    wait_idle("t1_idle");
    chk("t1_nframes", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("t1_byte", rx_q[0], 8'h31);

    // Back-to-back
    clear_rx();
    strobe(8'h2B, e);
    strobe(8'h3D, e);
    uout_valid = 1'b0;
    wait_idle("t2_idle");
    chk("t2_nframes", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("t2_byte0", rx_q[0], 8'h2B);
      chk("t2_byte1", rx_q[1], 8'h3D);
      chk("t2_gap", st_q[1] - st_q[0], FRAME);
    end

    // Overflow burst of 18 strobes
    clear_rx();
    for (int i = 0; i < 18; i++) begin
      strobe(8'h30 + 8'(i), e);
      if (i == 16) begin
        chk("t3_full_at17", fifo_full, 1);
        chk("t3_noovf_at17", overflow, 0);
      end
    end
    uout_valid = 1'b0;
    chk("t3_ovf_at18", overflow, 1);
    chk("t3_full_at18", fifo_full, 1);
    wait_idle("t3_idle");
    chk("t3_nframes", rx_q.size(), 17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) chk("t3_byte", rx_q[i], 8'h30 + 8'(i));
    chk("t3_ovf_sticky", overflow, 1);

    // Reset during data bit 3 of the first of three queued frames
    clear_rx();
    strobe(8'h41, e);
    strobe(8'h42, e);
    strobe(8'h43, e);
    uout_valid = 1'b0;
    fall = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin fall = cyc; break; end
    end
    chk("t4_fall", fall - e, FRAME + 2 - 2 - FRAME + 0);
    repeat (4 * C + 1) @(negedge clk);
    chk("t4_bit3", tx, 0);
    n_rst = 1'b0;
    @(negedge clk);
    chk("t4_tx", tx, 1);
    chk("t4_busy", tx_busy, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_full", fifo_full, 0);
    n_rst = 1'b1;
    seen_low = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) seen_low = 1;
    end
    chk("t4_quiet", seen_low, 0);
    chk("t4_nframes", rx_q.size(), 0);

    // Parity bytes and frame length
    clear_rx();
    strobe(8'h37, e);
    strobe(8'h33, e);
    uout_valid = 1'b0;
    wait_idle("t5_idle");
    chk("t5_nframes", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("t5_byte0", rx_q[0], 8'h37);
      chk("t5_byte1", rx_q[1], 8'h33);
      chk("t5_len", st_q[1] - st_q[0], FRAME);
`ifdef UART_TX_PARITY_EN
      chk("t5_par0", par_q[0], 1);
      chk("t5_par1", par_q[1], 0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
